// File: rtl/mult_arbiter_pkg.sv
// Shared definitions for the round-robin front end of a shared multiplier:
// FSM encoding and the default watchdog limit.
package mult_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_BUSY = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam int TMO_DEFAULT = 15;

endpackage

// File: rtl/mult_arbiter_rr_grant.sv
// Round-robin grant: picks the first asserted request at or after ptr,
// wrapping modulo N. Purely combinational, one-hot or zero output.
module rr_grant #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest match wins.
  always_comb begin
    gnt = '0;
    sum = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IW + 1)'(k);
      if (sum >= (IW + 1)'(N)) begin
        sum = sum - (IW + 1)'(N);
      end
      idx = sum[IW-1:0];
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Arbitrates N requesters onto one shared multiplier, one operation at a time,
// with a watchdog that reports an error response if the multiplier stalls.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int W   = 4,
  parameter int N   = 2,
  parameter int TMO = TMO_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  input  logic [N*W-1:0]       req_a,
  input  logic [N*W-1:0]       req_b,
  output logic [N-1:0]         req_ready,
  output logic                 rsp_valid,
  output logic [$clog2(N)-1:0] rsp_id,
  output logic [2*W-1:0]       rsp_p,
  output logic                 rsp_err,
  output logic                 mult_load,
  output logic [W-1:0]         mult_a,
  output logic [W-1:0]         mult_b,
  input  logic [2*W-1:0]       mult_p,
  input  logic                 mult_valid
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TMO + 1);

  // Handshake: requester i is accepted on a rising edge where
  // req_valid[i] & req_ready[i]; req_ready is only ever raised in IDLE.
  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [IW-1:0]   id_q, id_d;
  logic [CW-1:0]   wdog_q, wdog_d, wdog_inc;
  logic [2*W-1:0]  rsp_p_q, rsp_p_d;
  logic            rsp_err_q, rsp_err_d;
  logic [IW-1:0]   rsp_id_q, rsp_id_d;

  logic [N-1:0]    gnt;
  logic [IW-1:0]   gnt_idx;
  logic [W-1:0]    gnt_a, gnt_b;

  rr_grant #(.N(N), .IW(IW)) u_rr_grant (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  always_comb begin
    gnt_idx = '0;
    gnt_a   = '0;
    gnt_b   = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        gnt_idx = IW'(i);
        gnt_a   = req_a[i*W +: W];
        gnt_b   = req_b[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    a_d       = a_q;
    b_d       = b_q;
    id_d      = id_q;
    wdog_d    = wdog_q;
    rsp_p_d   = rsp_p_q;
    rsp_err_d = rsp_err_q;
    rsp_id_d  = rsp_id_q;
    wdog_inc  = wdog_q + 1'b1;
    req_ready = '0;
    mult_load = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = gnt;
        if (|gnt) begin
          a_d     = gnt_a;
          b_d     = gnt_b;
          id_d    = gnt_idx;
          ptr_d   = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        mult_load = 1'b1;
        wdog_d    = '0;
        state_d   = ST_BUSY;
      end
      ST_BUSY: begin
        wdog_d = wdog_inc;
        // The first BUSY cycle still shows the multiplier's stale idle flag.
        if (wdog_q != '0 && mult_valid) begin
          rsp_p_d   = mult_p;
          rsp_err_d = 1'b0;
          rsp_id_d  = id_q;
          state_d   = ST_RESP;
        end else if (wdog_inc == CW'(TMO)) begin
          rsp_p_d   = '0;
          rsp_err_d = 1'b1;
          rsp_id_d  = id_q;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= '0;
      wdog_q    <= '0;
      rsp_p_q   <= '0;
      rsp_err_q <= 1'b0;
      rsp_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      id_q      <= id_d;
      wdog_q    <= wdog_d;
      rsp_p_q   <= rsp_p_d;
      rsp_err_q <= rsp_err_d;
      rsp_id_q  <= rsp_id_d;
    end
  end

  assign mult_a  = a_q;
  assign mult_b  = b_q;
  assign rsp_p   = rsp_p_q;
  assign rsp_err = rsp_err_q;
  assign rsp_id  = rsp_id_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: latency-6 multiplier model with a stall mode, a
// round-robin reference model with an expected-response queue, scenario tasks.
module tb_mult_arbiter;

  localparam int W   = 4;
  localparam int N   = 2;
  localparam int TMO = 15;
  localparam int LAT = 6;
  localparam int IW  = $clog2(N);
  localparam int EW  = IW + 2 * W + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N*W-1:0]    req_a, req_b;
  logic [N-1:0]      req_ready;
  logic              rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic [2*W-1:0]    rsp_p;
  logic              rsp_err;
  logic              mult_load;
  logic [W-1:0]      mult_a, mult_b;
  logic [2*W-1:0]    mult_p;
  logic              mult_valid;

  int total = 0;
  int bad   = 0;
  int rsp_cnt = 0;
  int cyc = 0;
  int load_cyc = 0;
  int model_last = N - 1;
  int grant_log[$];
  logic [EW-1:0] exp_q[$];
  bit in_op = 0;
  bit prev_load = 0;
  logic [W-1:0] la, lb;

  always #5 clk = ~clk;

  mult_arbiter #(.W(W), .N(N), .TMO(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_p      (rsp_p),
    .rsp_err    (rsp_err),
    .mult_load  (mult_load),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_p     (mult_p),
    .mult_valid (mult_valid)
  );

  // Multiplier model: result ready LAT cycles after the load cycle; garbage
  // on mult_p while computing; never finishes while m_hang is set.
  logic           m_hang;
  int             m_cnt;
  logic [2*W-1:0] m_res, m_junk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mult_valid <= 1'b1;
      m_cnt      <= 0;
      m_res      <= '0;
      m_junk     <= '0;
    end else begin
      m_junk <= (2*W)'($urandom);
      if (mult_load) begin
        mult_valid <= 1'b0;
        m_cnt      <= LAT - 1;
        m_res      <= {{W{1'b0}}, mult_a} * {{W{1'b0}}, mult_b};
      end else if (!mult_valid && !m_hang && m_cnt == 1) begin
        mult_valid <= 1'b1;
        m_cnt      <= 0;
      end else if (m_cnt > 1) begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  assign mult_p = mult_valid ? m_res : m_junk;

  task automatic monitor();
    int exp_id;
    int j;
    logic [2*W-1:0] pa, pb;
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        exp_q.delete();
        model_last = N - 1;
        in_op = 0;
        prev_load = 0;
        total++;
        if (rsp_valid !== 1'b0) begin
          bad++;
          $display("FAIL rsp_in_reset: rsp_valid=%0b want 0", rsp_valid);
        end
      end else begin
        total++;
        if ($countones(req_ready) > 1 || ((in_op || mult_load) && req_ready != '0)) begin
          bad++;
          $display("FAIL ready_proto: req_ready=%b in_op=%0b load=%0b", req_ready, in_op, mult_load);
        end
        if (mult_load) begin
          total++;
          if (prev_load) begin
            bad++;
            $display("FAIL load_pulse: mult_load high two cycles at cyc %0d", cyc);
          end
          la = mult_a;
          lb = mult_b;
          in_op = 1;
          load_cyc = cyc;
        end else if (in_op) begin
          total++;
          if (mult_a !== la || mult_b !== lb) begin
            bad++;
            $display("FAIL operand_hold: a=%h b=%h want a=%h b=%h", mult_a, mult_b, la, lb);
          end
        end
        prev_load = mult_load;
        if (|(req_valid & req_ready)) begin
          exp_id = -1;
          for (int k = 1; k <= N; k++) begin
            j = (model_last + k) % N;
            if (exp_id < 0 && req_valid[j]) exp_id = j;
          end
          total++;
          if (req_ready !== N'(1 << exp_id)) begin
            bad++;
            $display("FAIL grant: req_ready=%b want one-hot index %0d", req_ready, exp_id);
          end
          pa = {{W{1'b0}}, req_a[exp_id*W +: W]};
          pb = {{W{1'b0}}, req_b[exp_id*W +: W]};
          if (m_hang) exp_q.push_back({IW'(exp_id), {(2*W){1'b0}}, 1'b1});
          else        exp_q.push_back({IW'(exp_id), pa * pb, 1'b0});
          grant_log.push_back(exp_id);
          model_last = exp_id;
        end
        if (rsp_valid) begin
          rsp_cnt++;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL rsp_unexpected: id=%0d p=%h err=%0b", rsp_id, rsp_p, rsp_err);
          end else begin
            e = exp_q.pop_front();
            if ({rsp_id, rsp_p, rsp_err} !== e) begin
              bad++;
              $display("FAIL rsp: id=%0d p=%h err=%0b want id=%0d p=%h err=%0b",
                       rsp_id, rsp_p, rsp_err, e[EW-1 -: IW], e[2*W:1], e[0]);
            end
            total++;
            if (cyc - load_cyc != (e[0] ? TMO + 1 : LAT + 1)) begin
              bad++;
              $display("FAIL rsp_timing: %0d cycles after load want %0d",
                       cyc - load_cyc, e[0] ? TMO + 1 : LAT + 1);
            end
          end
          in_op = 0;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (req_ready !== '0 || rsp_valid !== 1'b0 || mult_load !== 1'b0 || rsp_err !== 1'b0 ||
        rsp_p !== '0 || rsp_id !== '0 || mult_a !== '0 || mult_b !== '0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%b rv=%0b ld=%0b err=%0b p=%h id=%0d a=%h b=%h",
               req_ready, rsp_valid, mult_load, rsp_err, rsp_p, rsp_id, mult_a, mult_b);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_contention();
    int g0, base, seen, t, id;
    g0 = grant_log.size();
    base = rsp_cnt;
    seen = g0;
    @(posedge clk); #1;
    req_a = (N*W)'($urandom);
    req_b = (N*W)'($urandom);
    req_valid = '1;
    t = 0;
    while (seen < g0 + 4 && t < 400) begin
      @(posedge clk); #1;
      t++;
      if (grant_log.size() > seen) begin
        id = grant_log[seen];
        seen++;
        req_a[id*W +: W] = W'($urandom);
        req_b[id*W +: W] = W'($urandom);
        if (seen == g0 + 4) req_valid = '0;
      end
    end
    req_valid = '0;
    for (int k = 0; k < 300 && rsp_cnt < base + 4; k++) @(posedge clk);
    total++;
    if (rsp_cnt != base + 4 || grant_log.size() != g0 + 4) begin
      bad++;
      $display("FAIL contention_count: rsp=%0d grants=%0d want 4", rsp_cnt - base, grant_log.size() - g0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (grant_log[g0 + k] != k % 2) begin
          bad++;
          $display("FAIL contention_order: grant %0d went to %0d want %0d", k, grant_log[g0 + k], k % 2);
        end
      end
    end
  endtask

  task automatic test_single();
    int base;
    base = rsp_cnt;
    @(posedge clk); #1;
    req_a[0 +: W] = 4'd13;
    req_b[0 +: W] = 4'd11;
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = '0;
    for (int k = 0; k < 100 && rsp_cnt < base + 1; k++) @(posedge clk);
    total++;
    if (rsp_cnt != base + 1 || rsp_id !== IW'(0) || rsp_p !== 8'd143 || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL single: n=%0d id=%0d p=%0d err=%0b want n=1 id=0 p=143 err=0",
               rsp_cnt - base, rsp_id, rsp_p, rsp_err);
    end
  endtask

  task automatic test_extremes();
    int base;
    base = rsp_cnt;
    @(posedge clk); #1;
    req_a[W +: W] = 4'hF;
    req_b[W +: W] = 4'hF;
    req_valid = 2'b10;
    @(posedge clk); #1;
    req_valid = '0;
    for (int k = 0; k < 100 && rsp_cnt < base + 1; k++) @(posedge clk);
    total++;
    if (rsp_cnt != base + 1 || rsp_p !== 8'hE1 || rsp_id !== IW'(1) || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL extreme_max: p=%h id=%0d err=%0b want p=e1 id=1 err=0", rsp_p, rsp_id, rsp_err);
    end
    @(posedge clk); #1;
    req_a[0 +: W] = 4'h0;
    req_b[0 +: W] = 4'h9;
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = '0;
    for (int k = 0; k < 100 && rsp_cnt < base + 2; k++) @(posedge clk);
    total++;
    if (rsp_cnt != base + 2 || rsp_p !== 8'h00 || rsp_id !== IW'(0)) begin
      bad++;
      $display("FAIL extreme_zero: p=%h id=%0d want p=00 id=0", rsp_p, rsp_id);
    end
  endtask

  task automatic test_timeout();
    int base;
    logic [W-1:0] a, b;
    logic [2*W-1:0] want;
    base = rsp_cnt;
    m_hang = 1'b1;
    @(posedge clk); #1;
    req_a[0 +: W] = W'($urandom);
    req_b[0 +: W] = W'($urandom);
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = '0;
    for (int k = 0; k < 100 && rsp_cnt < base + 1; k++) @(posedge clk);
    total++;
    if (rsp_cnt != base + 1 || rsp_err !== 1'b1 || rsp_p !== '0) begin
      bad++;
      $display("FAIL timeout_rsp: n=%0d err=%0b p=%h want n=1 err=1 p=0", rsp_cnt - base, rsp_err, rsp_p);
    end
    m_hang = 1'b0;
    a = W'($urandom_range(1, 15));
    b = W'($urandom_range(1, 15));
    want = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    @(posedge clk); #1;
    req_a[W +: W] = a;
    req_b[W +: W] = b;
    req_valid = 2'b10;
    @(posedge clk); #1;
    req_valid = '0;
    for (int k = 0; k < 100 && rsp_cnt < base + 2; k++) @(posedge clk);
    total++;
    if (rsp_cnt != base + 2 || rsp_err !== 1'b0 || rsp_p !== want || rsp_id !== IW'(1)) begin
      bad++;
      $display("FAIL timeout_recover: err=%0b p=%h id=%0d want err=0 p=%h id=1", rsp_err, rsp_p, rsp_id, want);
    end
  endtask

  task automatic test_reset_mid_busy();
    int base;
    logic [W-1:0] a, b;
    logic [2*W-1:0] want;
    base = rsp_cnt;
    @(posedge clk); #1;
    req_a[0 +: W] = W'($urandom);
    req_b[0 +: W] = W'($urandom);
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (req_ready !== '0 || rsp_valid !== 1'b0 || mult_load !== 1'b0 || rsp_err !== 1'b0 ||
        rsp_p !== '0 || rsp_id !== '0 || mult_a !== '0 || mult_b !== '0) begin
      bad++;
      $display("FAIL reset_busy_outputs: rv=%0b ld=%0b err=%0b p=%h id=%0d a=%h b=%h",
               rsp_valid, mult_load, rsp_err, rsp_p, rsp_id, mult_a, mult_b);
    end
    a = W'($urandom);
    b = W'($urandom);
    want = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    req_a[W +: W] = a;
    req_b[W +: W] = b;
    req_valid = 2'b10;
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk); #1;
    total++;
    if (req_ready !== 2'b10) begin
      bad++;
      $display("FAIL reset_first_grant: req_ready=%b want 10", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    for (int k = 0; k < 100 && rsp_cnt < base + 1; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    total++;
    if (rsp_cnt != base + 1 || rsp_p !== want || rsp_id !== IW'(1) || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy_after: n=%0d p=%h id=%0d err=%0b want n=1 p=%h id=1 err=0",
               rsp_cnt - base, rsp_p, rsp_id, rsp_err, want);
    end
  endtask

  task automatic test_random();
    int g0, base, t;
    g0 = grant_log.size();
    base = rsp_cnt;
    t = 0;
    while (grant_log.size() < g0 + 30 && t < 3000) begin
      @(posedge clk); #1;
      t++;
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      req_a = (N*W)'($urandom);
      req_b = (N*W)'($urandom);
      if (grant_log.size() >= g0 + 30) req_valid = '0;
    end
    req_valid = '0;
    for (int k = 0; k < 100 && rsp_cnt < base + (grant_log.size() - g0); k++) @(posedge clk);
    total++;
    if (grant_log.size() < g0 + 30 || rsp_cnt != base + (grant_log.size() - g0) || exp_q.size() != 0) begin
      bad++;
      $display("FAIL random_traffic: grants=%0d rsps=%0d pending=%0d",
               grant_log.size() - g0, rsp_cnt - base, exp_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    m_hang = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_contention();
    test_single();
    test_extremes();
    test_timeout();
    test_reset_mid_busy();
    test_random();
    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "global timeout");
  end

endmodule
